// File: rtl/uart_rx_if.sv
// Byte-side valid/ready bundle between uart_rx (master) and its consumer (slave).
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun_err;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;
`endif

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun_err,
`ifdef UART_RX_PARITY_EN
    output parity_err,
`endif
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun_err,
`ifdef UART_RX_PARITY_EN
    input  parity_err,
`endif
    output rx_ready
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver presenting bytes on a valid/ready handshake.
// Define UART_RX_PARITY_EN to add a parity bit, the parity_odd input and parity_err.
module uart_rx #(
  parameter int CLK_DIV    = 27,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      rx_in,
  input  logic      rx_en,
`ifdef UART_RX_PARITY_EN
  input  logic      parity_odd,
`endif
  output logic      busy,
  uart_rx_if.master bus
);

  localparam int TickW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SampW = $clog2(OVERSAMPLE);
  localparam int BitW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TickW-1:0] TickLast = TickW'(CLK_DIV - 1);
  localparam logic [SampW-1:0] SampMid  = SampW'(OVERSAMPLE / 2 - 1);
  localparam logic [SampW-1:0] SampLast = SampW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_e;

  state_e               state_q;
  logic                 rxMeta_q;
  logic                 rxSync_q;
  logic [TickW-1:0]     tickCnt_q;
  logic [TickW-1:0]     tickCnt_d;
  logic                 tick;
  logic [SampW-1:0]     sampleCnt_q;
  logic [BitW-1:0]      bitCnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 busy_q;
  logic                 frameDone;
  logic [DATA_BITS-1:0] rxData_q;
  logic                 rxValid_q;
  logic                 frameErr_q;
  logic                 overrunErr_q;
`ifdef UART_RX_PARITY_EN
  logic                 parityOdd_q;
  logic                 parityBit_q;
  logic                 parityErr_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= rx_in;
      rxSync_q <= rxMeta_q;
    end
  end

  // The divider only runs during a frame so every frame starts phase-aligned to its start edge.
  always_comb begin
    tick      = (state_q != IDLE) && (tickCnt_q == TickLast);
    tickCnt_d = tickCnt_q + TickW'(1);
    if ((state_q == IDLE) || tick) begin
      tickCnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tickCnt_q <= '0;
    end else begin
      tickCnt_q <= tickCnt_d;
    end
  end

  assign frameDone = (state_q == STOP) && tick && (sampleCnt_q == SampLast);

  // After the start bit is confirmed at its middle, each full bit period lands on the next mid-bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sampleCnt_q <= '0;
      bitCnt_q    <= '0;
      shift_q     <= '0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityOdd_q <= 1'b0;
      parityBit_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_en && !rxSync_q) begin
            state_q     <= START;
            sampleCnt_q <= '0;
            bitCnt_q    <= '0;
            busy_q      <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (sampleCnt_q == SampMid) begin
              if (rxSync_q) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end else begin
                sampleCnt_q <= '0;
                state_q     <= DATA;
`ifdef UART_RX_PARITY_EN
                parityOdd_q <= parity_odd;
`endif
              end
            end else begin
              sampleCnt_q <= sampleCnt_q + SampW'(1);
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (sampleCnt_q == SampLast) begin
              shift_q     <= {rxSync_q, shift_q[DATA_BITS-1:1]};
              sampleCnt_q <= '0;
              if (bitCnt_q == BitLast) begin
`ifdef UART_RX_PARITY_EN
                state_q <= PARITY;
`else
                state_q <= STOP;
`endif
              end else begin
                bitCnt_q <= bitCnt_q + BitW'(1);
              end
            end else begin
              sampleCnt_q <= sampleCnt_q + SampW'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (sampleCnt_q == SampLast) begin
              parityBit_q <= rxSync_q;
              sampleCnt_q <= '0;
              state_q     <= STOP;
            end else begin
              sampleCnt_q <= sampleCnt_q + SampW'(1);
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (frameDone) begin
              sampleCnt_q <= '0;
              if (rxSync_q) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q <= BREAK;
              end
            end else begin
              sampleCnt_q <= sampleCnt_q + SampW'(1);
            end
          end
        end
        BREAK: begin
          if (rxSync_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // A completed byte only replaces the presented one if that one is absent or leaving this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rxData_q     <= '0;
      rxValid_q    <= 1'b0;
      frameErr_q   <= 1'b0;
      overrunErr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityErr_q  <= 1'b0;
`endif
    end else if (frameDone) begin
      if (!rxValid_q || bus.rx_ready) begin
        rxData_q   <= shift_q;
        frameErr_q <= ~rxSync_q;
        rxValid_q  <= 1'b1;
`ifdef UART_RX_PARITY_EN
        parityErr_q <= ((^shift_q) ^ parityBit_q) != parityOdd_q;
`endif
        if (rxValid_q) begin
          overrunErr_q <= 1'b0;
        end
      end else begin
        overrunErr_q <= 1'b1;
      end
    end else if (rxValid_q && bus.rx_ready) begin
      rxValid_q    <= 1'b0;
      overrunErr_q <= 1'b0;
    end
  end

  assign busy            = busy_q;
  assign bus.rx_data     = rxData_q;
  assign bus.rx_valid    = rxValid_q;
  assign bus.frame_err   = frameErr_q;
  assign bus.overrun_err = overrunErr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err  = parityErr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: drives serial frames bit-by-bit and checks the byte handshake.
// Also builds with UART_RX_PARITY_EN, inserting a parity bit into every frame.
module tb_uart_rx;

  localparam int ClkDiv     = 2;
  localparam int OverSample = 16;
  localparam int DataBits   = 8;
  localparam int BitCycles  = ClkDiv * OverSample;
`ifdef UART_RX_PARITY_EN
  localparam int FrameBits  = 11;
`else
  localparam int FrameBits  = 10;
`endif
  localparam int FrameCycles = FrameBits * BitCycles;
  // Stop bit is sampled two synchroniser cycles plus half a bit after its leading edge.
  localparam int DoneCycle   = (FrameBits - 1) * BitCycles + 2 + BitCycles / 2;

  logic clk = 1'b0;
  logic reset;
  logic rxIn;
  logic rxEn;
  logic busy;
`ifdef UART_RX_PARITY_EN
  logic parityOdd;
`endif

  int         vectorCount = 0;
  int         failCount   = 0;
  int         hsCount     = 0;
  int         hsBase;
  logic [7:0] hsData      = '0;
  logic       hsFerr      = 1'b0;
`ifdef UART_RX_PARITY_EN
  logic       hsPerr      = 1'b0;
`endif
  logic [10:0] frame;

  uart_rx_if #(.DATA_BITS(DataBits)) rxBus ();

  uart_rx #(
    .CLK_DIV   (ClkDiv),
    .OVERSAMPLE(OverSample),
    .DATA_BITS (DataBits)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_in     (rxIn),
    .rx_en     (rxEn),
`ifdef UART_RX_PARITY_EN
    .parity_odd(parityOdd),
`endif
    .busy      (busy),
    .bus       (rxBus)
  );

  always #5 clk = ~clk;

  // Inputs change 2 time units after each rising edge; the monitor looks at the falling edge,
  // so what it sees is exactly what the next rising edge will act on.
  always @(negedge clk) begin
    if (!reset && rxBus.rx_valid && rxBus.rx_ready) begin
      hsCount = hsCount + 1;
      hsData  = rxBus.rx_data;
      hsFerr  = rxBus.frame_err;
`ifdef UART_RX_PARITY_EN
      hsPerr  = rxBus.parity_err;
`endif
    end
  end

  task automatic waitCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  // Start bit, data LSB first, optional correct parity, then the stop bit.
  function automatic logic [10:0] makeFrame(input logic [7:0] data, input logic stopBit);
    logic [10:0] f;
    f      = 11'h7FF;
    f[0]   = 1'b0;
    f[8:1] = data;
`ifdef UART_RX_PARITY_EN
    f[9]   = (^data) ^ parityOdd;
    f[10]  = stopBit;
`else
    f[9]   = stopBit;
`endif
    return f;
  endfunction

  // Drives frame cycles [firstCycle, lastCycle); pulseCycle >= 0 raises rx_ready for that one cycle.
  task automatic applyStimulus(input logic [10:0] bits, input int firstCycle, input int lastCycle,
                               input int pulseCycle);
    for (int c = firstCycle; c < lastCycle; c++) begin
      rxIn = bits[c / BitCycles];
      if (pulseCycle >= 0) rxBus.rx_ready = (c == pulseCycle);
      waitCycle();
    end
    if (pulseCycle >= 0) rxBus.rx_ready = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    rxIn           = 1'b1;
    rxEn           = 1'b1;
    rxBus.rx_ready = 1'b0;
`ifdef UART_RX_PARITY_EN
    parityOdd      = 1'b0;
`endif
    repeat (3) waitCycle();
    reset = 1'b0;
    waitCycle();

    checkOutput("reset data", 32'(rxBus.rx_data), 32'h00);
    checkOutput("reset valid", 32'(rxBus.rx_valid), 32'd0);
    checkOutput("reset ferr", 32'(rxBus.frame_err), 32'd0);
    checkOutput("reset overrun", 32'(rxBus.overrun_err), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
`ifdef UART_RX_PARITY_EN
    checkOutput("reset perr", 32'(rxBus.parity_err), 32'd0);
`endif

    // Nominal 0xA5 with the consumer always ready
    rxBus.rx_ready = 1'b1;
    hsBase = hsCount;
    frame  = makeFrame(8'hA5, 1'b1);
    applyStimulus(frame, 0, 100, -1);
    checkOutput("nominal busy mid", 32'(busy), 32'd1);
    applyStimulus(frame, 100, FrameCycles, -1);
    repeat (2) waitCycle();
    checkOutput("nominal count", 32'(hsCount - hsBase), 32'd1);
    checkOutput("nominal data", 32'(hsData), 32'hA5);
    checkOutput("nominal ferr", 32'(hsFerr), 32'd0);
`ifdef UART_RX_PARITY_EN
    checkOutput("nominal perr", 32'(hsPerr), 32'd0);
`endif
    checkOutput("nominal overrun", 32'(rxBus.overrun_err), 32'd0);
    checkOutput("nominal busy end", 32'(busy), 32'd0);
    checkOutput("nominal valid end", 32'(rxBus.rx_valid), 32'd0);

    // Start glitch: four low clocks are rejected at the middle of the start bit
    hsBase = hsCount;
    rxIn   = 1'b0;
    repeat (4) waitCycle();
    rxIn = 1'b1;
    repeat (4) waitCycle();
    checkOutput("glitch busy rise", 32'(busy), 32'd1);
    repeat (30) waitCycle();
    checkOutput("glitch busy fall", 32'(busy), 32'd0);
    checkOutput("glitch valid", 32'(rxBus.rx_valid), 32'd0);
    checkOutput("glitch count", 32'(hsCount - hsBase), 32'd0);

    // Framing error followed by a held-low break
    hsBase = hsCount;
    applyStimulus(makeFrame(8'h3C, 1'b0), 0, FrameCycles, -1);
    rxIn = 1'b0;
    repeat (3 * BitCycles) waitCycle();
    checkOutput("break count", 32'(hsCount - hsBase), 32'd1);
    checkOutput("break data", 32'(hsData), 32'h3C);
    checkOutput("break ferr", 32'(hsFerr), 32'd1);
    checkOutput("break busy held", 32'(busy), 32'd1);
    rxIn = 1'b1;
    repeat (8) waitCycle();
    checkOutput("break busy release", 32'(busy), 32'd0);
    applyStimulus(makeFrame(8'h55, 1'b1), 0, FrameCycles, -1);
    repeat (2) waitCycle();
    checkOutput("after break count", 32'(hsCount - hsBase), 32'd2);
    checkOutput("after break data", 32'(hsData), 32'h55);
    checkOutput("after break ferr", 32'(hsFerr), 32'd0);

    // Overrun: consumer stalled across two frames
    rxBus.rx_ready = 1'b0;
    applyStimulus(makeFrame(8'h11, 1'b1), 0, FrameCycles, -1);
    applyStimulus(makeFrame(8'h22, 1'b1), 0, FrameCycles, -1);
    repeat (2) waitCycle();
    checkOutput("overrun valid", 32'(rxBus.rx_valid), 32'd1);
    checkOutput("overrun data kept", 32'(rxBus.rx_data), 32'h11);
    checkOutput("overrun flag", 32'(rxBus.overrun_err), 32'd1);
    rxBus.rx_ready = 1'b1;
    waitCycle();
    rxBus.rx_ready = 1'b0;
    waitCycle();
    checkOutput("overrun drained valid", 32'(rxBus.rx_valid), 32'd0);
    checkOutput("overrun drained flag", 32'(rxBus.overrun_err), 32'd0);
    checkOutput("overrun drained data", 32'(hsData), 32'h11);

    // Handshake lands in the exact completion cycle of the next byte
    applyStimulus(makeFrame(8'h11, 1'b1), 0, FrameCycles, -1);
    hsBase = hsCount;
    applyStimulus(makeFrame(8'h22, 1'b1), 0, FrameCycles, DoneCycle);
    repeat (2) waitCycle();
    checkOutput("simul valid", 32'(rxBus.rx_valid), 32'd1);
    checkOutput("simul data", 32'(rxBus.rx_data), 32'h22);
    checkOutput("simul overrun", 32'(rxBus.overrun_err), 32'd0);
    checkOutput("simul handshakes", 32'(hsCount - hsBase), 32'd1);
    checkOutput("simul old byte", 32'(hsData), 32'h11);

    // Reset in the middle of data bit 4 of 0xFF, with 0x22 still presented
    applyStimulus(makeFrame(8'hFF, 1'b1), 0, 5 * BitCycles + BitCycles / 2, -1);
    checkOutput("midreset busy before", 32'(busy), 32'd1);
    reset = 1'b1;
    waitCycle();
    reset = 1'b0;
    checkOutput("midreset data", 32'(rxBus.rx_data), 32'h00);
    checkOutput("midreset valid", 32'(rxBus.rx_valid), 32'd0);
    checkOutput("midreset ferr", 32'(rxBus.frame_err), 32'd0);
    checkOutput("midreset overrun", 32'(rxBus.overrun_err), 32'd0);
    checkOutput("midreset busy", 32'(busy), 32'd0);
`ifdef UART_RX_PARITY_EN
    checkOutput("midreset perr", 32'(rxBus.parity_err), 32'd0);
`endif
    rxIn = 1'b1;
    repeat (2 * BitCycles) waitCycle();
    checkOutput("midreset no frame", 32'(rxBus.rx_valid), 32'd0);

    rxBus.rx_ready = 1'b1;
    hsBase = hsCount;
    frame  = makeFrame(8'h81, 1'b1);
`ifdef UART_RX_PARITY_EN
    frame[9] = ~frame[9];
`endif
    applyStimulus(frame, 0, FrameCycles, -1);
    repeat (2) waitCycle();
    checkOutput("post reset count", 32'(hsCount - hsBase), 32'd1);
    checkOutput("post reset data", 32'(hsData), 32'h81);
    checkOutput("post reset ferr", 32'(hsFerr), 32'd0);
`ifdef UART_RX_PARITY_EN
    checkOutput("post reset perr", 32'(hsPerr), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver, the receive-side counterpart of the transmit path and its baud generator.
- Oversamples the serial line with an internal baud-tick divider, finds the start bit, and samples data bits LSB-first at mid-bit.
- Checks the stop bit and presents each byte on a valid/ready handshake to the downstream register/FIFO logic.

Parameters:
CLK_DIV, 27, system clocks per oversample tick (50 MHz / (115200*16) ≈ 27); legal range ≥ 1
OVERSAMPLE, 16, oversample ticks per bit; even, ≥ 4
DATA_BITS, 8, data bits per frame; 5..8

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
rx_in  input  1  asynchronous serial line, idle high
rx_en  input  1  enables detection of new start bits
rx_data  output  DATA_BITS  received byte, LSB = first bit on line
rx_valid  output  1  rx_data/frame_err hold a byte not yet taken
rx_ready  input  1  consumer accepts; transfer when rx_valid && rx_ready
frame_err  output  1  stop bit of the presented byte was 0; qualified by rx_valid
overrun_err  output  1  sticky: a completed byte was dropped because rx_valid was still high
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, active-high): state IDLE; rx_data=0, rx_valid=0, frame_err=0, overrun_err=0, busy=0; both synchroniser flops=1; tick and sample counters=0. Reset mid-frame abandons the frame; no rx_valid.
- Synchroniser: 2 flops on rx_in; rx_s is the second flop. All decisions use rx_s (2-cycle input latency).
- Tick divider: counts 0..CLK_DIV-1 while state != IDLE; tick=1 when count==CLK_DIV-1, then wraps to 0. Held at 0 in IDLE. Counter wide enough for CLK_DIV-1.
- Sample counter: counts ticks within a bit, 0..OVERSAMPLE-1; bit counter 0..DATA_BITS-1.
- IDLE: if rx_en && rx_s==0, go to START and clear the counters. rx_en low only blocks new starts; a frame in progress always completes.
- START: at tick with sample count == OVERSAMPLE/2-1 (mid start bit):
  - rx_s==1: glitch, return to IDLE.
  - rx_s==0: clear sample count, go to DATA.
- DATA: on every tick where sample count == OVERSAMPLE-1, shift rx_s into the MSB of the shift register (right shift, so LSB-first order is kept) and clear the sample count. After DATA_BITS samples, go to STOP.
- STOP: at the same mid-bit point, sample rx_s.
  - Complete the frame: load rx_data from the shift register and set frame_err = ~rx_s. Both become visible the next cycle together with rx_valid=1.
  - rx_s==1: go to IDLE.
  - rx_s==0: go to BREAK.
- BREAK: wait until rx_s==1, then go to IDLE. A long low line must not re-trigger a start.
- Output handshake:
  - rx_valid stays high until the cycle rx_valid && rx_ready; it clears the next cycle.
  - rx_data and frame_err stay stable while rx_valid is high.
- Overrun (frame completes while rx_valid=1 and rx_ready=0):
  - New byte and its frame_err are discarded; the old byte stays presented.
  - overrun_err is set and stays high until the next completed handshake or reset.
- Simultaneous completion and handshake (rx_valid && rx_ready in the completion cycle): old byte transfers, new byte loads, rx_valid stays 1, no overrun.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP; one extra bit sampled at mid-bit.
  - Input port parity_odd (1 = odd parity, 0 = even), sampled when the start bit is confirmed.
  - Output port parity_err: 1 if XOR(data bits, parity bit) != parity_odd. Loaded, held and qualified exactly like frame_err. Reset value 0.
- Undefined: no PARITY state and no parity ports; STOP follows the last data bit directly.

Test Plan:
- Nominal byte: CLK_DIV=2, OVERSAMPLE=16, rx_en=1, rx_ready=1; send 0xA5 (start, 1,0,1,0,0,1,0,1, stop=1) → one rx_valid pulse, rx_data=0xA5, frame_err=0, overrun_err=0, busy back to 0.
- Start glitch: rx_in low for 4 clocks, then high → no frame; busy rises, returns to IDLE after half a bit; rx_valid stays 0.
- Framing error / break: send 0x3C with stop=0, then hold rx_in low 3 bit-times → rx_valid with rx_data=0x3C, frame_err=1; no second frame until rx_in returns high; next byte 0x55 received cleanly.
- Overrun: rx_ready=0; send 0x11 then 0x22 → rx_data stays 0x11, overrun_err=1. Raise rx_ready for 1 cycle → handshake, overrun_err=0, rx_valid=0.
- Simultaneous: hold 0x11 pending, pulse rx_ready in the exact completion cycle of 0x22 → rx_valid stays 1, rx_data=0x22, overrun_err=0.
- Reset mid-frame: assert reset during bit 4 of 0xFF → all outputs 0 next cycle, no rx_valid. Following byte 0x81 received correctly. With UART_RX_PARITY_EN, parity_odd=0 and 0x81 sent with parity 1 → parity_err=1.
